// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one multi-cycle add/subtract unit
// between NREQ requesters, with a tagged, backpressured response channel.

module alu_share_arbiter_chk #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic                     clk,
    input logic                     reset,
    input logic [NREQ-1:0]          req_valid,
    input logic [NREQ-1:0]          req_ready,
    input logic                     rsp_valid,
    input logic                     rsp_ready,
    input logic [$clog2(NREQ)-1:0]  rsp_id,
    input logic [WIDTH-1:0]         rsp_data
);

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));

    a_ready_valid: assert property (@(posedge clk) disable iff (reset)
        (req_ready & ~req_valid) == '0);

    a_no_grant_in_resp: assert property (@(posedge clk) disable iff (reset)
        rsp_valid |-> (req_ready == '0));

    a_rsp_hold: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)));

endmodule

module alu_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_op,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_carry,
    output logic                     busy,
    output logic [15:0]              ops_done
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(EXEC_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns {found, index} of the first valid requester after last, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
        logic           found;
        logic [IDW-1:0] idx;
        int             cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last) + k) % NREQ;
            if (!found && valid[IDW'(cand)]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // Borrow of the subtract lands in the extra top bit, same as the add carry.
    function automatic logic [WIDTH:0] alu_f(input logic             sub,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        if (sub) begin
            return {1'b0, a} - {1'b0, b};
        end else begin
            return {1'b0, a} + {1'b0, b};
        end
    endfunction

    state_t           state_q,      state_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   gnt_q,        gnt_d;
    logic             op_q,         op_d;
    logic [WIDTH-1:0] a_q,          a_d;
    logic [WIDTH-1:0] b_q,          b_d;
    logic [IDW-1:0]   rsp_id_q,     rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q,   rsp_data_d;
    logic             rsp_carry_q,  rsp_carry_d;
    logic             rsp_valid_q,  rsp_valid_d;
    logic             busy_q,       busy_d;
    logic [15:0]      ops_done_q,   ops_done_d;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [IDW:0]     pick_s;
    logic             accept_s;
    logic [IDW-1:0]   win_s;
    logic [WIDTH:0]   alu_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    assign pick_s   = rr_pick(req_valid, last_grant_q);
    assign win_s    = pick_s[IDW-1:0];
    // A grant is never signalled in a reset cycle, since it would be discarded.
    assign accept_s = (state_q == ST_IDLE) && pick_s[IDW] && !reset;
    assign alu_s    = alu_f(op_q, a_q, b_q);

    // Arbitration grant decode.
    always_comb begin
        req_ready = '0;
        if (accept_s) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath capture logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_valid_d  = rsp_valid_q;
        busy_d       = busy_q;
        ops_done_d   = ops_done_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d      = ST_EXEC;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    last_grant_d = win_s;
                    gnt_d        = win_s;
                    op_d         = req_op[win_s];
                    a_d          = a_arr[win_s];
                    b_d          = b_arr[win_s];
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CW'(EXEC_CYCLES - 1)) begin
                    state_d     = ST_RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = gnt_q;
                    rsp_data_d  = alu_s[WIDTH-1:0];
                    rsp_carry_d = alu_s[WIDTH];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    ops_done_d  = ops_done_q + 16'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            gnt_q        <= '0;
            op_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            ops_done_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            ops_done_q   <= ops_done_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;

    alu_share_arbiter_chk #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a transaction-timestamp model
// that predicts grants, response timing and results every cycle.

module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int EC   = 2;

    logic             clk;
    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_op;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]  req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_carry;
    logic             busy;
    logic [15:0]      ops_done;

    alu_share_arbiter #(
        .NREQ        (NREQ),
        .WIDTH       (W),
        .EXEC_CYCLES (EC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;

    // Model: one operation in flight, described by its grant and the cycle its response appears.
    bit m_have;
    int m_resp_cyc;
    int m_last;
    int m_gnt;
    int m_pend_data;
    int m_pend_carry;
    int m_id;
    int m_data;
    int m_carry;
    int m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_have     = 1'b0;
        m_resp_cyc = -1;
        m_last     = NREQ - 1;
        m_gnt      = 0;
        m_id       = 0;
        m_data     = 0;
        m_carry    = 0;
        m_done     = 0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the grant, advance the model.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic rr, input logic rst);
        int w;
        int idx;
        int ai;
        int bi;
        logic [NREQ-1:0] exp_rdy;

        if (m_have && cyc == m_resp_cyc) begin
            m_id    = m_gnt;
            m_data  = m_pend_data;
            m_carry = m_pend_carry;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(m_have && cyc >= m_resp_cyc));
        check("busy",      32'(busy),      32'(m_have));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("rsp_data",  32'(rsp_data),  32'(m_data));
        check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        check("ops_done",  32'(ops_done),  32'(m_done));

        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = rr;
        reset     = rst;
        #1;

        w = -1;
        if (!m_have && !rst) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (w < 0 && ((32'(v) >> idx) & 32'd1) != 32'd0) w = idx;
            end
        end
        exp_rdy = (w >= 0) ? NREQ'(1 << w) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));

        if (rst) begin
            model_reset();
        end else if (w >= 0) begin
            ai = int'((a >> (w * W)) & 32'hFF);
            bi = int'((b >> (w * W)) & 32'hFF);
            m_have     = 1'b1;
            m_gnt      = w;
            m_last     = w;
            m_resp_cyc = cyc + EC + 1;
            if (((32'(op) >> w) & 32'd1) != 32'd0) begin
                m_pend_data  = (ai - bi) & 255;
                m_pend_carry = (ai < bi) ? 1 : 0;
            end else begin
                m_pend_data  = (ai + bi) & 255;
                m_pend_carry = (ai + bi > 255) ? 1 : 0;
            end
        end else if (m_have && cyc >= m_resp_cyc && rr) begin
            m_have = 1'b0;
            m_done = (m_done + 1) & 16'hFFFF;
        end

        @(negedge clk);
        cyc++;
    endtask

    // A single operation from requester id; its operand A is corrupted right after acceptance.
    task automatic one_op(input int id, input logic op, input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        logic [NREQ-1:0] opv;
        av  = $urandom;
        bv  = $urandom;
        av  = (av & ~(32'hFF << (id * W))) | (32'(a) << (id * W));
        bv  = (bv & ~(32'hFF << (id * W))) | (32'(b) << (id * W));
        opv = NREQ'($urandom);
        opv = op ? (opv | NREQ'(1 << id)) : (opv & ~NREQ'(1 << id));
        step(NREQ'(1 << id), opv, av, bv, 1'b1, 1'b0);
        av = av ^ (32'hAA << (id * W));
        step('0, opv, av, bv, 1'b1, 1'b0);
        repeat (3) step('0, opv, av, bv, 1'b1, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);

        one_op(2, 1'b0, 8'h0F, 8'h01);
        one_op(1, 1'b0, 8'hFF, 8'h01);
        one_op(3, 1'b1, 8'h05, 8'h07);
        one_op(0, 1'b1, 8'h07, 8'h05);

        // Round-robin with every requester pending from reset.
        step('0, '0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 24; i++)
            step('1, NREQ'($urandom), $urandom, $urandom, 1'b1, 1'b0);

        // Backpressure with other requests pending.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++)
                step('1, NREQ'($urandom), $urandom, $urandom, 1'b0, 1'b0);
            for (int i = 0; i < 6; i++)
                step('1, NREQ'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        end

        // Reset during EXEC discards the operation.
        repeat (4) step('0, '0, '0, '0, 1'b1, 1'b0);
        step('1, NREQ'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        step('1, NREQ'($urandom), $urandom, $urandom, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            step('1, NREQ'($urandom), $urandom, $urandom, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++)
            step(NREQ'($urandom), NREQ'($urandom), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
